// File: rtl/aes_ctr_scheduler_if.sv
// Bundle of the request, engine and output handshakes around the AES-CTR job scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface aes_ctr_scheduler_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [7:0]   req0_nonce_a;
  logic [7:0]   req0_nonce_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [7:0]   req1_nonce_a;
  logic [7:0]   req1_nonce_b;
  logic         eng_rst_n;
  logic         eng_mode;
  logic [7:0]   eng_nonce_a;
  logic [7:0]   eng_nonce_b;
  logic         eng_batch_valid;
  logic [511:0] eng_batch;
  logic         eng_finished;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic         out_id;
  logic         out_last;
  logic         busy;
  logic         err_ovf;
  logic         err_early;

  modport slave (
    input  req0_valid, req0_nonce_a, req0_nonce_b,
    input  req1_valid, req1_nonce_a, req1_nonce_b,
    input  eng_batch_valid, eng_batch, eng_finished, out_ready,
    output req0_ready, req1_ready,
    output eng_rst_n, eng_mode, eng_nonce_a, eng_nonce_b,
    output out_valid, out_data, out_id, out_last,
    output busy, err_ovf, err_early
  );

  modport master (
    output req0_valid, req0_nonce_a, req0_nonce_b,
    output req1_valid, req1_nonce_a, req1_nonce_b,
    output eng_batch_valid, eng_batch, eng_finished, out_ready,
    input  req0_ready, req1_ready,
    input  eng_rst_n, eng_mode, eng_nonce_a, eng_nonce_b,
    input  out_valid, out_data, out_id, out_last,
    input  busy, err_ovf, err_early
  );
endinterface

// File: rtl/aes_ctr_scheduler.sv
// Round-robin scheduler for XOF/PRF AES-CTR jobs: launches the engine, counts its
// 512-bit batches and forwards them through a 2-entry output FIFO.
//
// state  | meaning
// IDLE   | engine held in reset, waiting for a request to grant
// LAUNCH | job latched, batch counter cleared, engine still in reset
// RUN    | engine released, batches pushed into the FIFO
// DRAIN  | engine back in reset, waiting for the FIFO to empty
module aes_ctr_scheduler #(
  parameter int XOF_BATCHES = 11,
  parameter int PRF_BATCHES = 2
) (
  input logic                 clk,
  input logic                 rst,
  aes_ctr_scheduler_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [3:0] XOF_TGT = 4'(XOF_BATCHES);
  localparam logic [3:0] PRF_TGT = 4'(PRF_BATCHES);

  logic [1:0]   state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         mode_q, mode_d;
  logic [7:0]   nonce_a_q, nonce_a_d;
  logic [7:0]   nonce_b_q, nonce_b_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         err_ovf_q, err_ovf_d;
  logic         err_early_q, err_early_d;
  logic [513:0] fifo_q [2];
  logic [513:0] fifo_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   fcnt_q, fcnt_d;

  logic         take;
  logic         gnt_sel;
  logic [3:0]   target;
  logic [3:0]   cnt_inc;
  logic         batch_in;
  logic         is_last;
  logic         pop;
  logic         full;
  logic         push_ok;
  logic         ovf;
  logic [513:0] head;

  // Ready is gated by rst so a request held during reset is never acknowledged.
  assign gnt_sel  = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign take     = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;
  assign target   = mode_q ? PRF_TGT : XOF_TGT;
  assign cnt_inc  = cnt_q + 4'd1;
  assign batch_in = (state_q == S_RUN) && bus.eng_batch_valid;
  assign is_last  = batch_in && (cnt_inc == target);
  assign pop      = (fcnt_q != 2'd0) && bus.out_ready;
  assign full     = (fcnt_q == 2'd2);
  assign push_ok  = batch_in && (!full || pop);
  assign ovf      = batch_in && full && !pop;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mode_d       = mode_q;
    nonce_a_d    = nonce_a_q;
    nonce_b_d    = nonce_b_q;
    cnt_d        = cnt_q;
    err_ovf_d    = err_ovf_q | ovf;
    err_early_d  = err_early_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          last_grant_d = gnt_sel;
          mode_d       = gnt_sel;
          nonce_a_d    = gnt_sel ? bus.req1_nonce_a : bus.req0_nonce_a;
          nonce_b_d    = gnt_sel ? bus.req1_nonce_b : bus.req0_nonce_b;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = 4'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A dropped batch still counts, so the job length is never stretched.
        if (batch_in) cnt_d = cnt_inc;
        if (is_last) begin
          state_d = S_DRAIN;
        end else if (bus.eng_finished && (cnt_q < target)) begin
          err_early_d = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      default: begin
        if (fcnt_q == 2'd0) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = {bus.eng_batch, mode_q, is_last};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      mode_q       <= 1'b0;
      nonce_a_q    <= 8'd0;
      nonce_b_q    <= 8'd0;
      cnt_q        <= 4'd0;
      err_ovf_q    <= 1'b0;
      err_early_q  <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fcnt_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mode_q       <= mode_d;
      nonce_a_q    <= nonce_a_d;
      nonce_b_q    <= nonce_b_d;
      cnt_q        <= cnt_d;
      err_ovf_q    <= err_ovf_d;
      err_early_q  <= err_early_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign head = fifo_q[rd_ptr_q];

  assign bus.req0_ready  = take && !gnt_sel;
  assign bus.req1_ready  = take && gnt_sel;
  assign bus.eng_rst_n   = (state_q == S_RUN);
  assign bus.eng_mode    = mode_q;
  assign bus.eng_nonce_a = nonce_a_q;
  assign bus.eng_nonce_b = nonce_b_q;
  assign bus.out_valid   = (fcnt_q != 2'd0);
  assign bus.out_data    = head[513:2];
  assign bus.out_id      = head[1];
  assign bus.out_last    = head[0];
  assign bus.busy        = (state_q != S_IDLE) || (fcnt_q != 2'd0);
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_early   = err_early_q;

endmodule

// File: tb/tb_aes_ctr_scheduler.sv
// Scoreboard bench for aes_ctr_scheduler: directed jobs push expected batches into a
// queue, and a negedge monitor pops and compares every accepted output.
module tb_aes_ctr_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_ctr_scheduler_if bus ();

  aes_ctr_scheduler #(.XOF_BATCHES(11), .PRF_BATCHES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [513:0] exp_q[$];

  function automatic logic [511:0] mk(input int tag, input int n);
    logic [31:0] w;
    w = 32'hC0DE0000 | 32'(tag * 256) | 32'(n);
    return {16{w}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every output accepted by the sink must match the head of the scoreboard.
  initial begin
    logic [513:0] act, e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        act = {bus.out_data, bus.out_id, bus.out_last};
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_unexpected: got id=%0b last=%0b data=%h expected nothing",
                   act[1], act[0], act[513:2]);
        end else begin
          e = exp_q.pop_front();
          if (act === e) n_pass++;
          else $display("FAIL out_batch: got id=%0b last=%0b data=%h expected id=%0b last=%0b data=%h",
                        act[1], act[0], act[513:2], e[1], e[0], e[513:2]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.eng_batch_valid = 1'b0;
    bus.eng_finished = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Raise the requested valids, wait for the grant, then check LAUNCH and RUN.
  task automatic grant(input logic v0, input logic v1, input logic w);
    logic [1:0] rdy;
    bus.req0_nonce_a = 8'h12;
    bus.req0_nonce_b = 8'h34;
    bus.req1_nonce_a = 8'h56;
    bus.req1_nonce_b = 8'h78;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    rdy = 2'b00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rdy = {bus.req1_ready, bus.req0_ready};
      if (rdy != 2'b00) break;
    end
    chk("grant_ready", 64'(rdy), w ? 64'h2 : 64'h1);
    @(posedge clk);
    #1;
    if (w) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
    chk("launch_eng_rst_n", 64'(bus.eng_rst_n), 64'h0);
    chk("launch_mode", 64'(bus.eng_mode), 64'(w));
    chk("launch_nonces", 64'({bus.eng_nonce_a, bus.eng_nonce_b}), w ? 64'h5678 : 64'h1234);
    tick();
    chk("run_eng_rst_n", 64'(bus.eng_rst_n), 64'h1);
  endtask

  task automatic pulse(input int tag, input int n, input logic id, input logic push,
                       input logic last);
    bus.eng_batch = mk(tag, n);
    bus.eng_batch_valid = 1'b1;
    if (push) exp_q.push_back({mk(tag, n), id, last});
    tick();
    bus.eng_batch_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic b;
    b = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      b = bus.busy;
      if (b == 1'b0) break;
    end
    chk("idle_reached", 64'(b), 64'h0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b0;
    bus.req0_nonce_a = 8'h12;
    bus.req0_nonce_b = 8'h34;
    bus.req1_nonce_a = 8'h56;
    bus.req1_nonce_b = 8'h78;
    bus.eng_batch_valid = 1'b0;
    bus.eng_batch = '0;
    bus.eng_finished = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_req0_ready", 64'(bus.req0_ready), 64'h0);
    chk("rst_eng_rst_n", 64'(bus.eng_rst_n), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_errs", 64'({bus.err_ovf, bus.err_early}), 64'h0);
    chk("rst_latches", 64'({bus.eng_mode, bus.eng_nonce_a, bus.eng_nonce_b}), 64'h0);

    // Single XOF job, sink always ready.
    do_reset();
    bus.out_ready = 1'b1;
    grant(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) pulse(1, i, 1'b0, 1'b1, i == 11);
    chk("xof_last_valid", 64'({bus.out_valid, bus.out_last}), 64'h3);
    chk("xof_drain_eng_rst_n", 64'(bus.eng_rst_n), 64'h0);
    chk("xof_drain_busy", 64'(bus.busy), 64'h1);
    tick();
    chk("xof_after_pop", 64'({bus.busy, bus.out_valid}), 64'h2);
    tick();
    chk("xof_idle_one_after_pop", 64'(bus.busy), 64'h0);

    // Tie from reset: port 0 first, then port 1 as a PRF job.
    do_reset();
    bus.out_ready = 1'b1;
    grant(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 11; i++) pulse(2, i, 1'b0, 1'b1, i == 11);
    grant(1'b0, 1'b1, 1'b1);
    pulse(2, 21, 1'b1, 1'b1, 1'b0);
    pulse(2, 22, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // Stalled sink: third batch dropped but still counted.
    do_reset();
    bus.out_ready = 1'b0;
    grant(1'b1, 1'b0, 1'b0);
    pulse(3, 1, 1'b0, 1'b1, 1'b0);
    pulse(3, 2, 1'b0, 1'b1, 1'b0);
    chk("ovf_not_yet", 64'(bus.err_ovf), 64'h0);
    pulse(3, 3, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 64'(bus.err_ovf), 64'h1);
    chk("ovf_held_valid", 64'(bus.out_valid), 64'h1);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("ovf_drained", 64'(bus.out_valid), 64'h0);
    for (int i = 4; i <= 11; i++) pulse(3, i, 1'b0, 1'b1, i == 11);
    wait_idle();
    chk("ovf_sticky", 64'(bus.err_ovf), 64'h1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    bus.out_ready = 1'b0;
    grant(1'b1, 1'b0, 1'b0);
    pulse(4, 1, 1'b0, 1'b1, 1'b0);
    pulse(4, 2, 1'b0, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    pulse(4, 3, 1'b0, 1'b1, 1'b0);
    chk("pushpop_no_ovf", 64'(bus.err_ovf), 64'h0);
    for (int i = 4; i <= 11; i++) pulse(4, i, 1'b0, 1'b1, i == 11);
    wait_idle();
    chk("pushpop_no_ovf_end", 64'(bus.err_ovf), 64'h0);

    // PRF job cut short by the engine.
    do_reset();
    bus.out_ready = 1'b1;
    grant(1'b0, 1'b1, 1'b1);
    pulse(5, 1, 1'b1, 1'b1, 1'b0);
    bus.eng_finished = 1'b1;
    tick();
    bus.eng_finished = 1'b0;
    chk("early_flag", 64'(bus.err_early), 64'h1);
    chk("early_drain", 64'({bus.eng_rst_n, bus.busy}), 64'h1);
    wait_idle();
    pulse(5, 9, 1'b1, 1'b0, 1'b0);
    chk("idle_batch_ignored", 64'(bus.out_valid), 64'h0);
    chk("early_sticky", 64'(bus.err_early), 64'h1);

    // Reset mid-job with one queued batch.
    do_reset();
    bus.out_ready = 1'b0;
    grant(1'b1, 1'b0, 1'b0);
    pulse(6, 1, 1'b0, 1'b0, 1'b0);
    chk("midrst_queued", 64'(bus.out_valid), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_eng_rst_n", 64'(bus.eng_rst_n), 64'h0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("midrst_nothing_emitted", 64'({bus.out_valid, bus.busy}), 64'h0);
    grant(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) pulse(7, i, 1'b0, 1'b1, i == 11);
    wait_idle();

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_ctr_scheduler.md
AES_CTR_SCHEDULER -- requirements
Module: aes_ctr_scheduler

Interface
REQ-001 Parameter XOF_BATCHES, default 11, 512-bit batches per XOF job (44 blocks / 4).
REQ-002 Parameter PRF_BATCHES, default 2, 512-bit batches per PRF job (8 blocks / 4).
REQ-003 Port clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port req0_valid/req0_ready  in/out  1/1  XOF job request handshake; req0_nonce_a, req0_nonce_b  in  8 each.
REQ-006 Port req1_valid/req1_ready  in/out  1/1  PRF job request handshake; req1_nonce_a, req1_nonce_b  in  8 each.
REQ-007 Port eng_rst_n  out  1  engine restart; low holds the engine in reset.
REQ-008 Port eng_mode  out  1  0 = XOF, 1 = PRF; eng_nonce_a, eng_nonce_b  out  8 each.
REQ-009 Port eng_batch_valid  in  1  one-cycle pulse, eng_batch valid; eng_batch  in  512.
REQ-010 Port eng_finished  in  1  engine terminal flag.
REQ-011 Port out_valid/out_ready  out/in  1/1  output handshake; out_data  out  512; out_id  out  1 (requester); out_last  out  1.
REQ-012 Port busy  out  1; err_ovf  out  1; err_early  out  1.

Function
REQ-013 FSM states IDLE, LAUNCH, RUN, DRAIN; 2-bit encoding.
REQ-014 IDLE: with a valid request pending, pick a winner, pulse its reqN_ready for 1 cycle, latch nonces, mode = requester index, id = index, go LAUNCH.
REQ-015 Arbitration round-robin: both valid -> grant index != last_grant; single valid -> grant it; last_grant resets to 1, so port 0 wins the first tie.
REQ-016 Requests are accepted only in IDLE; reqN_ready is 0 in all other states.
REQ-017 eng_rst_n = 0 in IDLE and LAUNCH, 1 in RUN; LAUNCH lasts exactly 1 cycle, then RUN.
REQ-018 eng_mode and eng_nonce_* are driven from the job latches; they are stable from LAUNCH through DRAIN.
REQ-019 RUN: each eng_batch_valid pulse pushes {eng_batch, id, last} into a 2-entry FIFO and increments the 4-bit batch counter.
REQ-020 last = 1 when the post-increment count equals XOF_BATCHES (mode 0) or PRF_BATCHES (mode 1); that push moves the FSM to DRAIN in the same cycle.
REQ-021 DRAIN: eng_rst_n = 0; FSM waits for an empty FIFO, then returns to IDLE.
REQ-022 busy = 1 in any state other than IDLE, or while the FIFO is non-empty.
REQ-023 FIFO head drives out_data, out_id and out_last; out_valid = FIFO non-empty; pop on out_valid & out_ready.
REQ-024 Push and pop in the same cycle on a full FIFO are both honoured; occupancy stays at 2 and no overflow occurs.
REQ-025 A push to a full FIFO without a simultaneous pop drops the batch, sets err_ovf, and still increments the counter.
REQ-026 eng_batch_valid outside RUN is ignored.
REQ-027 eng_finished = 1 in RUN with count < target sets err_early and moves the FSM to DRAIN; no last flag is emitted.
REQ-028 err_ovf and err_early are sticky until rst.
REQ-029 The batch counter clears in LAUNCH.
REQ-030 Output latency: a batch captured into an empty FIFO presents out_valid on the next cycle.

Reset
REQ-031 rst asynchronously forces: state IDLE, eng_rst_n 0, req*_ready 0, out_valid 0, FIFO empty, counter 0, last_grant 1, err flags 0, latches 0.
REQ-032 rst mid-job discards the FIFO contents and the job; nothing is emitted after rst deasserts until a new grant.

Verification
REQ-033 req0 only, nonce_a=0x12, nonce_b=0x34, out_ready=1, 11 engine pulses -> 11 outputs with out_id=0, out_last=1 only on the 11th, eng_mode=0; FSM back in IDLE 1 cycle after the final pop.
REQ-034 req0 and req1 asserted together from reset -> port 0 granted first; the next IDLE grants port 1 (eng_mode=1, 2 outputs, last on the 2nd).
REQ-035 out_ready=0 for 3 engine pulses -> first 2 batches held in order, err_ovf=1, third dropped; raising out_ready drains 2 entries.
REQ-036 Full FIFO, push and pop in the same cycle -> no err_ovf; the output order is preserved.
REQ-037 PRF job, eng_finished=1 after 1 pulse -> err_early=1, DRAIN entered, 1 output with out_last=0.
REQ-038 rst asserted during RUN with 1 FIFO entry -> out_valid=0 and eng_rst_n=0 immediately; after release the next req0 is granted normally.
